// File: rtl/panel_bus_pkg.sv
// Shared defaults, arbiter state encoding and pixel-count helper for the panel write bus.
package panel_bus_pkg;

   localparam int DEFAULT_NUM_PANELS   = 8;
   localparam int DEFAULT_PANEL_WIDTH  = 64;
   localparam int DEFAULT_PANEL_HEIGHT = 64;
   localparam int DEFAULT_DATA_W       = 24;

   typedef enum logic [1:0] {
      WAIT  = 2'd0,
      NET   = 2'd1,
      FILL  = 2'd2,
      NOSIG = 2'd3
   } arb_state_t;

   function automatic int pixel_count(input int width, input int height);
      return width * height;
   endfunction

   localparam int PIXELS_PER_PANEL = pixel_count(DEFAULT_PANEL_WIDTH, DEFAULT_PANEL_HEIGHT);

endpackage

// File: rtl/panel_fill_sweeper.sv
// Solid-colour sweeper: walks every (panel, addr) pair once, one write per cycle,
// using the colour latched at start. abort drops the sweep position immediately.
module panel_fill_sweeper
   import panel_bus_pkg::*;
#(
   parameter int NUM_PANELS = DEFAULT_NUM_PANELS,
   parameter int PIXELS     = PIXELS_PER_PANEL,
   parameter int DATA_W     = DEFAULT_DATA_W
) (
   input  logic              display_clock,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] fill_color,
   output logic [7:0]        en,
   output logic [15:0]       addr,
   output logic [DATA_W-1:0] wdat,
   output logic              done
);

   localparam logic [15:0] LAST_ADDR  = 16'(PIXELS - 1);
   localparam logic [7:0]  LAST_PANEL = 8'(NUM_PANELS);

   logic              active_reg;
   logic [7:0]        panel_reg;
   logic [15:0]       addr_reg;
   logic [DATA_W-1:0] color_reg;

   logic last_addr;
   logic last_panel;

   assign last_addr  = (addr_reg == LAST_ADDR);
   assign last_panel = (panel_reg == LAST_PANEL);

   // Outputs describe the step being offered this cycle; the arbiter registers them.
   assign en   = active_reg ? panel_reg : 8'd0;
   assign addr = addr_reg;
   assign wdat = color_reg;
   assign done = active_reg && last_addr && last_panel;

   always_ff @(posedge display_clock or posedge rst) begin
      if (rst) begin
         active_reg <= 1'b0;
         panel_reg  <= 8'd0;
         addr_reg   <= 16'd0;
         color_reg  <= '0;
      end else if (start) begin
         active_reg <= 1'b1;
         panel_reg  <= 8'd1;
         addr_reg   <= 16'd0;
         color_reg  <= fill_color;
      end else if (abort || done) begin
         active_reg <= 1'b0;
      end else if (active_reg) begin
         if (last_addr) begin
            addr_reg  <= 16'd0;
            panel_reg <= panel_reg + 8'd1;
         end else begin
            addr_reg <= addr_reg + 16'd1;
         end
      end
   end

endmodule

// File: rtl/panel_bus_arbiter.sv
// Sole driver of the shared panel write bus: network stream first, idle fill sweep second.
// Drop/frame counters exist only when PANEL_BUS_ARBITER_STATS_EN is defined.
module panel_bus_arbiter
   import panel_bus_pkg::*;
#(
   parameter int NUM_PANELS     = DEFAULT_NUM_PANELS,
   parameter int PANEL_WIDTH    = DEFAULT_PANEL_WIDTH,
   parameter int PANEL_HEIGHT   = DEFAULT_PANEL_HEIGHT,
   parameter int DATA_W         = DEFAULT_DATA_W,
   parameter int TIMEOUT_CYCLES = 25000000
) (
   input  logic              display_clock,
   input  logic              rst,
   input  logic              net_valid,
   output logic              net_ready,
   input  logic [7:0]        net_panel,
   input  logic [15:0]       net_addr,
   input  logic [DATA_W-1:0] net_data,
   input  logic              net_last,
   input  logic [DATA_W-1:0] fill_color,
   output logic [7:0]        ctrl_en,
   output logic [15:0]       ctrl_addr,
   output logic [DATA_W-1:0] ctrl_wdat,
   output logic              link_active,
   output logic [15:0]       drop_count,
   output logic [15:0]       frame_count
);

   localparam int          PIXELS    = pixel_count(PANEL_WIDTH, PANEL_HEIGHT);
   localparam int          CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] PANEL_MAX = 32'(NUM_PANELS);
   localparam logic [31:0] PIX_LIMIT = 32'(PIXELS);

   arb_state_t        state_reg;
   logic [CNT_W-1:0]  idle_cnt_reg;
   logic              net_ready_reg;
   logic              link_active_reg;
   logic [7:0]        ctrl_en_reg;
   logic [15:0]       ctrl_addr_reg;
   logic [DATA_W-1:0] ctrl_wdat_reg;

   logic              accept;
   logic              beat_ok;
   logic              idle_hit;
   logic              fill_start;
   logic              sweep_abort;
   logic [7:0]        sweep_en;
   logic [15:0]       sweep_addr;
   logic [DATA_W-1:0] sweep_wdat;
   logic              sweep_done;

   assign accept   = net_valid && net_ready_reg;
   assign beat_ok  = (net_panel != 8'd0) && (32'(net_panel) <= PANEL_MAX) &&
                     (32'(net_addr) < PIX_LIMIT);
   assign idle_hit = (idle_cnt_reg == IDLE_LAST);

   // The sweeper loads on the same edge the FSM enters FILL, so its first step is
   // offered on the first FILL cycle. A beat always beats a pending timeout.
   assign fill_start  = !accept && idle_hit && ((state_reg == WAIT) || (state_reg == NET));
   assign sweep_abort = accept && (state_reg == FILL);

   panel_fill_sweeper #(
      .NUM_PANELS (NUM_PANELS),
      .PIXELS     (PIXELS),
      .DATA_W     (DATA_W)
   ) u_sweeper (
      .display_clock (display_clock),
      .rst           (rst),
      .start         (fill_start),
      .abort         (sweep_abort),
      .fill_color    (fill_color),
      .en            (sweep_en),
      .addr          (sweep_addr),
      .wdat          (sweep_wdat),
      .done          (sweep_done)
   );

   always_ff @(posedge display_clock or posedge rst) begin
      if (rst) begin
         state_reg       <= WAIT;
         idle_cnt_reg    <= '0;
         net_ready_reg   <= 1'b0;
         link_active_reg <= 1'b0;
         ctrl_en_reg     <= 8'd0;
         ctrl_addr_reg   <= 16'd0;
         ctrl_wdat_reg   <= '0;
      end else begin
         net_ready_reg <= 1'b1;
         ctrl_en_reg   <= 8'd0;
         if (accept) begin
            // Invalid beats are still accepted (and still count as link activity).
            if (beat_ok) begin
               ctrl_en_reg   <= net_panel;
               ctrl_addr_reg <= net_addr;
               ctrl_wdat_reg <= net_data;
            end
            state_reg       <= NET;
            link_active_reg <= 1'b1;
            idle_cnt_reg    <= '0;
         end else begin
            case (state_reg)
               WAIT, NET: begin
                  if (idle_hit) begin
                     state_reg       <= FILL;
                     link_active_reg <= 1'b0;
                     idle_cnt_reg    <= '0;
                  end else begin
                     idle_cnt_reg <= idle_cnt_reg + CNT_W'(1);
                  end
               end
               FILL: begin
                  ctrl_en_reg   <= sweep_en;
                  ctrl_addr_reg <= sweep_addr;
                  ctrl_wdat_reg <= sweep_wdat;
                  if (sweep_done) begin
                     state_reg <= NOSIG;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

   assign net_ready   = net_ready_reg;
   assign link_active = link_active_reg;
   assign ctrl_en     = ctrl_en_reg;
   assign ctrl_addr   = ctrl_addr_reg;
   assign ctrl_wdat   = ctrl_wdat_reg;

`ifdef PANEL_BUS_ARBITER_STATS_EN
   logic [15:0] drop_count_reg;
   logic [15:0] frame_count_reg;

   always_ff @(posedge display_clock or posedge rst) begin
      if (rst) begin
         drop_count_reg  <= 16'd0;
         frame_count_reg <= 16'd0;
      end else begin
         if (accept && !beat_ok && (drop_count_reg != 16'hFFFF)) begin
            drop_count_reg <= drop_count_reg + 16'd1;
         end
         if (accept && beat_ok && net_last) begin
            frame_count_reg <= frame_count_reg + 16'd1;
         end
      end
   end

   assign drop_count  = drop_count_reg;
   assign frame_count = frame_count_reg;
`else
   logic unused_net_last;

   assign unused_net_last = net_last;
   assign drop_count      = 16'd0;
   assign frame_count     = 16'd0;
`endif

endmodule

// File: tb/tb_panel_bus_arbiter.sv
// Directed bench for panel_bus_arbiter: a scoreboard queue holds every expected bus write.
module tb_panel_bus_arbiter;

`ifdef PANEL_BUS_ARBITER_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   typedef struct packed {
      logic [7:0]  en;
      logic [15:0] addr;
      logic [23:0] data;
   } wr_t;

   logic        display_clock = 1'b0;
   logic        rst;
   logic        net_valid;
   logic        net_ready;
   logic [7:0]  net_panel;
   logic [15:0] net_addr;
   logic [23:0] net_data;
   logic        net_last;
   logic [23:0] fill_color;
   logic [7:0]  ctrl_en;
   logic [15:0] ctrl_addr;
   logic [23:0] ctrl_wdat;
   logic        link_active;
   logic [15:0] drop_count;
   logic [15:0] frame_count;

   int  tests    = 0;
   int  fails    = 0;
   int  wr_count = 0;
   bit  mon_en   = 1'b0;
   wr_t last_wr;
   wr_t exp_q[$];

   always #5 display_clock = ~display_clock;

   panel_bus_arbiter #(
      .TIMEOUT_CYCLES (100)
   ) dut (
      .display_clock (display_clock),
      .rst           (rst),
      .net_valid     (net_valid),
      .net_ready     (net_ready),
      .net_panel     (net_panel),
      .net_addr      (net_addr),
      .net_data      (net_data),
      .net_last      (net_last),
      .fill_color    (fill_color),
      .ctrl_en       (ctrl_en),
      .ctrl_addr     (ctrl_addr),
      .ctrl_wdat     (ctrl_wdat),
      .link_active   (link_active),
      .drop_count    (drop_count),
      .frame_count   (frame_count)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Every write seen on the bus is popped against the scoreboard, in order.
   always @(negedge display_clock) begin
      wr_t got;
      wr_t e;
      if (mon_en && (ctrl_en !== 8'd0)) begin
         got      = {ctrl_en, ctrl_addr, ctrl_wdat};
         wr_count = wr_count + 1;
         last_wr  = got;
         tests++;
         assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_write observed=0x%0h expected=none", got);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tests++;
            assert (got === e) else begin
               fails++;
               $error("FAIL bus_write_%0d observed=0x%0h expected=0x%0h", wr_count, got, e);
            end
         end
      end
   end

   task automatic send_beat(input logic [7:0] p, input logic [15:0] a, input logic [23:0] d,
                            input logic l, input logic ok);
      wr_t w;
      net_panel = p;
      net_addr  = a;
      net_data  = d;
      net_last  = l;
      net_valid = 1'b1;
      if (ok) begin
         w.en   = p;
         w.addr = a;
         w.data = d;
         exp_q.push_back(w);
      end
      $display("[TB] beat panel=%0d addr=0x%0h data=0x%0h last=%0b expect_write=%0b", p, a, d, l, ok);
      @(posedge display_clock);
      #1;
      net_valid = 1'b0;
      net_last  = 1'b0;
   endtask

   task automatic push_sweep(input int count, input logic [23:0] color);
      wr_t w;
      int  p = 1;
      int  a = 0;
      for (int i = 0; i < count; i++) begin
         w.en   = 8'(p);
         w.addr = 16'(a);
         w.data = color;
         exp_q.push_back(w);
         a++;
         if (a == 4096) begin
            a = 0;
            p++;
         end
      end
   endtask

   task automatic settle();
      @(negedge display_clock);
      #1;
   endtask

   task automatic wait_writes(input int target, input int budget, input string tag);
      int n = 0;
      while ((wr_count < target) && (n < budget)) begin
         settle();
         n++;
      end
      check(tag, 64'(wr_count >= target), 64'(1));
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst        = 1'b1;
      net_valid  = 1'b0;
      net_panel  = 8'd0;
      net_addr   = 16'd0;
      net_data   = 24'd0;
      net_last   = 1'b0;
      fill_color = 24'h123456;
      repeat (3) @(posedge display_clock);
      settle();
      check("reset_ctrl_en", 64'(ctrl_en), 64'(0));
      check("reset_ctrl_addr", 64'(ctrl_addr), 64'(0));
      check("reset_ctrl_wdat", 64'(ctrl_wdat), 64'(0));
      check("reset_net_ready", 64'(net_ready), 64'(0));
      check("reset_link", 64'(link_active), 64'(0));
      check("reset_drops", 64'(drop_count), 64'(0));
      check("reset_frames", 64'(frame_count), 64'(0));
      rst    = 1'b0;
      mon_en = 1'b1;
      #1;
      check("ready_before_first_clock", 64'(net_ready), 64'(0));
      @(posedge display_clock);
      #1;
      check("ready_after_first_clock", 64'(net_ready), 64'(1));

      // First beat lands on the bus one cycle after acceptance.
      send_beat(8'd3, 16'h0105, 24'h00FF00, 1'b0, 1'b1);
      check("beat1_en", 64'(ctrl_en), 64'(3));
      check("beat1_addr", 64'(ctrl_addr), 64'(16'h0105));
      check("beat1_wdat", 64'(ctrl_wdat), 64'(24'h00FF00));
      check("beat1_link", 64'(link_active), 64'(1));

      // Out-of-range panel and address beats are dropped.
      send_beat(8'd0, 16'h0010, 24'h111111, 1'b0, 1'b0);
      check("drop_panel0_en", 64'(ctrl_en), 64'(0));
      send_beat(8'd9, 16'h0010, 24'h111111, 1'b0, 1'b0);
      check("drop_panel9_en", 64'(ctrl_en), 64'(0));
      send_beat(8'd1, 16'd4096, 24'h111111, 1'b0, 1'b0);
      check("drop_addr4096_en", 64'(ctrl_en), 64'(0));
      send_beat(8'd1, 16'd4095, 24'h222222, 1'b0, 1'b1);
      check("edge_addr4095_en", 64'(ctrl_en), 64'(1));
      check("edge_addr4095_addr", 64'(ctrl_addr), 64'(4095));
      check("drop_count_3", 64'(drop_count), 64'(STATS * 3));
      settle();

      // Full sweep; colour changes after the start must not leak into it.
      base = wr_count;
      push_sweep(8 * 4096, 24'h123456);
      wait_writes(base + 1, 300, "fill_started");
      fill_color = 24'h654321;
      check("link_in_fill", 64'(link_active), 64'(0));
      wait_writes(base + 8 * 4096, 33000, "fill_complete");
      check("fill_last_write", 64'(last_wr), 64'({8'd8, 16'd4095, 24'h123456}));
      check("fill_queue_drained", 64'(exp_q.size()), 64'(0));
      repeat (300) settle();
      check("nosig_no_writes", 64'(wr_count), 64'(base + 8 * 4096));
      check("nosig_link", 64'(link_active), 64'(0));

      send_beat(8'd1, 16'd10, 24'hAAAAAA, 1'b0, 1'b1);
      check("nosig_beat_link", 64'(link_active), 64'(1));
      settle();

      // Preempt the next sweep at step 5000, then confirm the following sweep restarts at (1,0).
      base = wr_count;
      push_sweep(5000, 24'h654321);
      wait_writes(base + 5000, 5400, "sweep_reached_5000");
      send_beat(8'd2, 16'd7, 24'h0F0F0F, 1'b0, 1'b1);
      check("preempt_en", 64'(ctrl_en), 64'(2));
      check("preempt_addr", 64'(ctrl_addr), 64'(7));
      check("preempt_link", 64'(link_active), 64'(1));
      fill_color = 24'h00BEEF;
      push_sweep(300, 24'h00BEEF);
      settle();
      base = wr_count;
      wait_writes(base + 300, 600, "resweep_300");

      // Asynchronous reset in the middle of that sweep.
      rst = 1'b1;
      #1;
      check("async_rst_en", 64'(ctrl_en), 64'(0));
      check("async_rst_link", 64'(link_active), 64'(0));
      check("async_rst_ready", 64'(net_ready), 64'(0));
      check("async_rst_drops", 64'(drop_count), 64'(0));
      base = wr_count;
      repeat (2) @(posedge display_clock);
      @(negedge display_clock);
      rst = 1'b0;
      #1;
      check("ready_low_after_release", 64'(net_ready), 64'(0));
      repeat (50) settle();
      check("wait_no_writes", 64'(wr_count), 64'(base));
      check("wait_link", 64'(link_active), 64'(0));
      check("wait_ready", 64'(net_ready), 64'(1));
      check("wait_queue_empty", 64'(exp_q.size()), 64'(0));

      // Three frames plus one invalid net_last beat.
      for (int f = 0; f < 3; f++) begin
         send_beat(8'd4, 16'(2 * f), 24'(32'h100 + f), 1'b0, 1'b1);
         send_beat(8'd4, 16'(2 * f + 1), 24'(32'h200 + f), 1'b1, 1'b1);
      end
      send_beat(8'd0, 16'd0, 24'h333333, 1'b1, 1'b0);
      settle();
      check("frame_count", 64'(frame_count), 64'(STATS * 3));
      check("drop_count_after_reset", 64'(drop_count), 64'(STATS));
      check("final_queue_empty", 64'(exp_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
